// File: rtl/regbank8w32_wr_pkg.sv
// Shared sizes, types and the one-hot index helper for the 8x32 register bank.
package regbank8w32_wr_pkg;

    localparam int NREG   = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] RST_VAL_DEF = 32'h0000_0000;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [NREG-1:0]   vec_t;

    function automatic vec_t idx_onehot(input addr_t addr);
        vec_t v;
        v = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regbank8w32_wr_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8
    import regbank8w32_wr_pkg::*;
(
    input  logic  en,
    input  addr_t addr,
    output vec_t  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = idx_onehot(addr);
        end
    end

endmodule

// File: rtl/regbank8w32_wr.sv
// 8x32 register bank: decoded write-back, two bypassed read ports, pending scoreboard.
module regbank8w32_wr
    import regbank8w32_wr_pkg::*;
#(
    parameter bit    ZERO_R0 = 1'b1,
    parameter data_t RST_VAL = RST_VAL_DEF
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        iss_valid,
    input  logic [2:0]  iss_addr,
    input  logic [2:0]  ra_addr,
    input  logic [2:0]  rb_addr,
    output logic [31:0] ra_data,
    output logic [31:0] rb_data,
    output logic        ra_busy,
    output logic        rb_busy,
    output logic [7:0]  pend
);

    localparam vec_t R0_MASK = ZERO_R0 ? vec_t'(1) : vec_t'(0);

    data_t regs [NREG];
    vec_t  wr_dec;
    vec_t  set_dec;
    vec_t  wr_vec;
    vec_t  set_vec;
    vec_t  pend_q;

    dec3to8 u_dec_wr (
        .en     (we),
        .addr   (waddr),
        .onehot (wr_dec)
    );

    dec3to8 u_dec_set (
        .en     (iss_valid),
        .addr   (iss_addr),
        .onehot (set_dec)
    );

    // r0 is stripped from both vectors so it never stores data nor goes pending
    assign wr_vec  = wr_dec  & ~R0_MASK;
    assign set_vec = set_dec & ~R0_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_vec[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // set dominates clear: a newer producer issued this cycle stays outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= ((pend_q & ~wr_vec) | set_vec) & ~R0_MASK;
        end
    end

    assign pend = pend_q;

    always_comb begin
        ra_data = regs[ra_addr];
        if (wr_vec[ra_addr]) begin
            ra_data = wdata;
        end else if (ZERO_R0 && ra_addr == '0) begin
            ra_data = '0;
        end
        ra_busy = pend_q[ra_addr] & ~wr_vec[ra_addr];
    end

    always_comb begin
        rb_data = regs[rb_addr];
        if (wr_vec[rb_addr]) begin
            rb_data = wdata;
        end else if (ZERO_R0 && rb_addr == '0) begin
            rb_data = '0;
        end
        rb_busy = pend_q[rb_addr] & ~wr_vec[rb_addr];
    end

endmodule

// File: tb/tb_regbank8w32_wr.sv
// Directed self-checking bench for regbank8w32_wr with ZERO_R0=1 and zero reset value.
module tb_regbank8w32_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic        iss_valid;
    logic [2:0]  iss_addr;
    logic [2:0]  ra_addr;
    logic [2:0]  rb_addr;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic        ra_busy;
    logic        rb_busy;
    logic [7:0]  pend;

    int total = 0;
    int bad   = 0;

    regbank8w32_wr dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .ra_addr   (ra_addr),
        .rb_addr   (rb_addr),
        .ra_data   (ra_data),
        .rb_data   (rb_data),
        .ra_busy   (ra_busy),
        .rb_busy   (rb_busy),
        .pend      (pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; we = 0; waddr = 0; wdata = 0; iss_valid = 0; iss_addr = 0;
    endtask

    initial begin
        idle();
        rst = 1; ra_addr = 0; rb_addr = 0;
        tick();
        tick();

        // reset then read
        rst = 0; ra_addr = 3; rb_addr = 7; #1;
        chk("rst_ra_data", ra_data, 32'h0);
        chk("rst_rb_data", rb_data, 32'h0);
        chk("rst_pend", {24'h0, pend}, 32'h00);
        chk("rst_ra_busy", {31'h0, ra_busy}, 32'h0);
        chk("rst_rb_busy", {31'h0, rb_busy}, 32'h0);

        // write / readback
        we = 1; waddr = 5; wdata = 32'hDEADBEEF; ra_addr = 5; #1;
        chk("wr5_bypass", ra_data, 32'hDEADBEEF);
        tick();
        idle(); #1;
        chk("wr5_readback", ra_data, 32'hDEADBEEF);
        for (int i = 0; i < 8; i++) begin
            if (i != 5) begin
                rb_addr = 3'(i); #1;
                chk($sformatf("wr5_other_r%0d", i), rb_data, 32'h0);
            end
        end

        // same-cycle bypass on both ports
        we = 1; waddr = 2; wdata = 32'h1111;
        tick();
        idle(); ra_addr = 2; rb_addr = 2; #1;
        chk("r2_pre", ra_data, 32'h1111);
        we = 1; waddr = 2; wdata = 32'h2222; #1;
        chk("byp_ra", ra_data, 32'h2222);
        chk("byp_rb", rb_data, 32'h2222);
        tick();
        idle(); #1;
        chk("byp_after", ra_data, 32'h2222);

        // r0 hardwired
        we = 1; waddr = 0; wdata = 32'hFFFFFFFF; iss_valid = 1; iss_addr = 0;
        ra_addr = 0; #1;
        chk("r0_bypass_data", ra_data, 32'h0);
        chk("r0_busy", {31'h0, ra_busy}, 32'h0);
        tick();
        idle(); #1;
        chk("r0_pend", {24'h0, pend}, 32'h00);
        chk("r0_data", ra_data, 32'h0);

        // scoreboard with simultaneous set and clear
        iss_valid = 1; iss_addr = 4;
        tick();
        idle(); ra_addr = 4; rb_addr = 4; #1;
        chk("sb_pend_set", {24'h0, pend}, 32'h10);
        chk("sb_ra_busy", {31'h0, ra_busy}, 32'h1);
        chk("sb_rb_busy", {31'h0, rb_busy}, 32'h1);
        iss_valid = 1; iss_addr = 4;
        tick();
        idle(); #1;
        chk("sb_waw_keep", {24'h0, pend}, 32'h10);
        we = 1; waddr = 4; wdata = 32'h4444; iss_valid = 1; iss_addr = 4; #1;
        chk("sb_both_ra_busy", {31'h0, ra_busy}, 32'h0);
        chk("sb_both_rb_busy", {31'h0, rb_busy}, 32'h0);
        chk("sb_both_ra_data", ra_data, 32'h4444);
        tick();
        idle(); #1;
        chk("sb_set_wins", {24'h0, pend}, 32'h10);
        chk("sb_busy_again", {31'h0, ra_busy}, 32'h1);
        we = 1; waddr = 4; wdata = 32'h5555;
        tick();
        idle(); #1;
        chk("sb_clear", {24'h0, pend}, 32'h00);
        chk("sb_clear_busy", {31'h0, ra_busy}, 32'h0);
        chk("sb_clear_data", ra_data, 32'h5555);

        // reset mid-operation
        iss_valid = 1; iss_addr = 2;
        tick();
        iss_valid = 1; iss_addr = 3; we = 1; waddr = 6; wdata = 32'hABCD;
        tick();
        idle(); ra_addr = 6; #1;
        chk("mid_pend", {24'h0, pend}, 32'h0C);
        chk("mid_r6", ra_data, 32'hABCD);
        rst = 1; we = 1; waddr = 6; wdata = 32'h1; iss_valid = 1; iss_addr = 1;
        tick();
        idle(); #1;
        chk("mid_rst_pend", {24'h0, pend}, 32'h00);
        chk("mid_rst_r6", ra_data, 32'h0);
        rb_addr = 2; #1;
        chk("mid_rst_r2", rb_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbank8w32_wr.md
Name: regbank8w32_wr

Overview:
- 8-entry x 32-bit register bank with a decoded write port, two combinational read ports and a per-register pending scoreboard.
- It is the write-side counterpart of the ALU's 8:1 32-bit operand select: a 3-bit address is decoded one-hot to steer write-back data into exactly one register.
- It sits between ALU write-back and operand fetch.
- It gives issue logic read-after-write bypass and busy flags.

Parameters:
- ZERO_R0, 1, when 1: register 0 reads as 0, ignores writes, and is never marked pending.
- RST_VAL, 32'h0000_0000, value loaded into every register on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write-back enable.
- waddr  in  3  write-back register index.
- wdata  in  32  write-back data.
- iss_valid  in  1  an instruction is issuing that will later write iss_addr.
- iss_addr  in  3  destination index of the issuing instruction.
- ra_addr  in  3  read port A index.
- rb_addr  in  3  read port B index.
- ra_data  out  32  read port A data (bypassed).
- rb_data  out  32  read port B data (bypassed).
- ra_busy  out  1  port A operand not yet available.
- rb_busy  out  1  port B operand not yet available.
- pend  out  8  scoreboard bits, bit i = register i awaiting write-back.

Behaviour:
- Reset:
  - Synchronous; sampled on the rising edge of clk.
  - All 8 registers load RST_VAL; pend loads 8'h00.
  - rst has priority over we and iss_valid in the same cycle.
  - After reset, reads return RST_VAL, or 0 for r0 when ZERO_R0=1.
- Write decode: waddr is decoded one-hot; when we=1 at the clock edge, reg[waddr] <= wdata. No other register changes.
- With ZERO_R0=1:
  - A write to index 0 is discarded.
  - A read of index 0 returns 32'h0.
  - pend[0] is held at 0.
- Read ports:
  - Purely combinational 8:1 selection by ra_addr/rb_addr; zero latency.
  - Bypass: if we=1 and waddr==ra_addr (and the address is not a discarded r0), ra_data=wdata in the same cycle. Port B behaves identically.
  - Both ports may address the same register; both are bypassed.
- Write latency: the written value is visible from the register array one cycle after the edge, and visible through bypass in the write cycle itself.
- Scoreboard, next-state per bit i:
  - set_i = iss_valid && iss_addr==i.
  - clr_i = we && waddr==i.
  - pend[i] <= set_i ? 1 : (clr_i ? 0 : pend[i]).
  - When set and clear hit the same index in one cycle, set wins: a newer producer is outstanding.
  - A write to a non-pending register is legal: data is written and pend is unchanged at 0.
  - A second issue to an already pending register keeps it at 1; the bank does no WAW counting.
- Busy:
  - ra_busy = pend[ra_addr] && !(we && waddr==ra_addr).
  - The write-back in the current cycle resolves the hazard via bypass. rb_busy is analogous.
  - With ZERO_R0=1 and address 0, busy is always 0.
- There is no backpressure; we and iss_valid are accepted every cycle.
- Out-of-range values cannot occur because all addresses are a full 3 bits.

Decomposition:
- Shared package holds:
  - NREG=8, ADDR_W=3, DATA_W=32.
  - The RST_VAL default.
  - The function idx_onehot(addr) returning an 8-bit one-hot.
- One sub-module, dec3to8: a 3-to-8 one-hot decoder with enable input. It is instantiated twice: once for the write strobe, once for the scoreboard set vector.
- Read selection and bypass stay inline.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then ra_addr=3, rb_addr=7 -> ra_data=rb_data=0, pend=8'h00, busy=0.
- Write/readback: we=1, waddr=5, wdata=32'hDEADBEEF for one cycle; next cycle we=0, ra_addr=5 -> ra_data=DEADBEEF; all other registers still 0.
- Same-cycle bypass: reg2=32'h1111; we=1, waddr=2, wdata=32'h2222, ra_addr=rb_addr=2 -> both ports read 2222 in that cycle; next cycle reg2=2222.
- R0 hardwired (ZERO_R0=1): we=1, waddr=0, wdata=32'hFFFFFFFF; iss_valid=1, iss_addr=0 -> ra_data(addr 0)=0, pend[0]=0, ra_busy=0.
- Scoreboard with simultaneous events:
  - iss_valid=1, iss_addr=4 -> pend=8'h10 and ra_busy(addr 4)=1.
  - Later cycle with we=1, waddr=4 and iss_valid=1, iss_addr=4 together -> pend stays 8'h10, ra_busy=0 that cycle (bypass).
  - Then we=1, waddr=4 alone -> pend=8'h00.
- Reset mid-operation: pend=8'h0C and reg6=32'hABCD; assert rst together with we=1, waddr=6, wdata=1 and iss_valid=1, iss_addr=1 -> next cycle pend=8'h00, reg6=0.
